// File: rtl/speaker_pkg.sv
// Shared constants, FSM state type and the volume-to-amplitude mapping for the tone generator.
// The optional amplitude ramp is enabled by defining TONE_RAMP_EN.
package speaker_pkg;

  localparam int unsigned DIV_W     = 22;
  localparam logic [15:0] AMP_STEP  = 16'h1000;
  localparam logic [2:0]  VOL_RST   = 3'd4;
  localparam logic [15:0] RAMP_STEP = 16'h0100;
  localparam int unsigned TICK_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } tone_state_e;

  // Level 7 tops out at 16'h7000, so the product always fits in 16 bits.
  function automatic logic [15:0] vol_target(input logic [2:0] level);
    return AMP_STEP * {13'd0, level};
  endfunction

endpackage

// File: rtl/vol_ctrl.sv
// Saturating volume level and the amplitude that follows it.
// With TONE_RAMP_EN defined the amplitude slews one RAMP_STEP per 256-cycle tick instead of jumping.
module vol_ctrl
  import speaker_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vol_up,
  input  logic        vol_down,
  output logic [2:0]  vol_level,
  output logic [15:0] amp
);

  logic [2:0]  level_q, level_d;
  logic [15:0] amp_q, amp_d;
  logic [15:0] target;

  always_comb begin
    level_d = level_q;
    if (vol_up && !vol_down && level_q != 3'd7)
      level_d = level_q + 3'd1;
    else if (vol_down && !vol_up && level_q != 3'd0)
      level_d = level_q - 3'd1;
  end

  assign target = vol_target(level_q);

`ifdef TONE_RAMP_EN
  logic [TICK_W-1:0] tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= '0;
    else        tick_q <= tick_q + TICK_W'(1);
  end

  // Clamp to target on the last step so the ramp never overshoots.
  always_comb begin
    amp_d = amp_q;
    if (tick_q == '1) begin
      if (amp_q < target)
        amp_d = (target - amp_q > RAMP_STEP) ? amp_q + RAMP_STEP : target;
      else if (amp_q > target)
        amp_d = (amp_q - target > RAMP_STEP) ? amp_q - RAMP_STEP : target;
    end
  end
`else
  always_comb begin
    amp_d = target;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= VOL_RST;
      amp_q   <= vol_target(VOL_RST);
    end else begin
      level_q <= level_d;
      amp_q   <= amp_d;
    end
  end

  assign vol_level = level_q;
  assign amp       = amp_q;

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone generator feeding the speaker serializer; notes switch only at half-period boundaries.
// state | meaning
// IDLE  | silent, ready for a note
// RUN   | tone playing, ready for the next note
// PEND  | tone playing, next note held until the current half-period ends
module tone_synth
  import speaker_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] note_div,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic             vol_up,
  input  logic             vol_down,
  output logic [2:0]       vol_level,
  output logic [15:0]      audio_left,
  output logic [15:0]      audio_right
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  tone_state_e      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] nxt_div_q, nxt_div_d;
  logic             phase_q, phase_d;
  logic             ready_q, ready_d;
  logic [15:0]      sample_q, sample_d;
  logic [15:0]      amp;
  logic             accept;
  logic             boundary;

  vol_ctrl u_vol_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .vol_up    (vol_up),
    .vol_down  (vol_down),
    .vol_level (vol_level),
    .amp       (amp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_div_q <= '0;
      nxt_div_q <= '0;
      phase_q   <= 1'b0;
      ready_q   <= 1'b1;
      sample_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      nxt_div_q <= nxt_div_d;
      phase_q   <= phase_d;
      ready_q   <= ready_d;
      sample_q  <= sample_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_div_d = cur_div_q;
    nxt_div_d = nxt_div_q;
    phase_d   = phase_q;
    ready_d   = ready_q;
    accept    = note_valid && ready_q;
    boundary  = (cnt_q == cur_div_q - ONE);

    case (state_q)
      IDLE: begin
        if (accept && note_div != '0) begin
          state_d   = RUN;
          cnt_d     = '0;
          phase_d   = 1'b1;
          cur_div_d = note_div;
        end
      end
      RUN: begin
        if (boundary) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + ONE;
        end
        if (accept) begin
          nxt_div_d = note_div;
          ready_d   = 1'b0;
          state_d   = PEND;
        end
      end
      PEND: begin
        if (boundary) begin
          cnt_d     = '0;
          cur_div_d = nxt_div_q;
          ready_d   = 1'b1;
          if (nxt_div_q != '0) begin
            state_d = RUN;
            phase_d = ~phase_q;
          end else begin
            state_d = IDLE;
            phase_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Negative half is the two's complement of the unsigned amplitude.
    if (state_q == IDLE || amp == '0)
      sample_d = '0;
    else if (phase_q)
      sample_d = amp;
    else
      sample_d = ~amp + 16'd1;
  end

  assign note_ready  = ready_q;
  assign audio_left  = sample_q;
  assign audio_right = sample_q;

endmodule

// File: tb/tb_tone_synth.sv
// Randomized and directed stimulus for tone_synth, checked against a timeline-based reference model.
module tb_tone_synth;
  import speaker_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DIV_W-1:0] note_div;
  logic             note_valid;
  logic             note_ready;
  logic             vol_up;
  logic             vol_down;
  logic [2:0]       vol_level;
  logic [15:0]      audio_left;
  logic [15:0]      audio_right;

  tone_synth dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .note_div    (note_div),
    .note_valid  (note_valid),
    .note_ready  (note_ready),
    .vol_up      (vol_up),
    .vol_down    (vol_down),
    .vol_level   (vol_level),
    .audio_left  (audio_left),
    .audio_right (audio_right)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a tone is a run of half-periods, each starting at an edge index.
  int          cyc;
  int          m_playing, m_sign, m_len, m_seg_start;
  int          m_pend, m_pend_div, m_ready, m_level;
  logic [15:0] m_amp;
  logic [15:0] m_exp;

  function automatic logic [15:0] tgt(input int level);
    return 16'(level * 4096);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_playing = 0; m_sign = 1; m_len = 0; m_seg_start = 0;
    m_pend = 0; m_pend_div = 0; m_ready = 1; m_level = 4;
    m_amp = tgt(4); m_exp = 16'h0000;
  endtask

  task automatic model_edge();
    int          rdy_before;
    int          d;
    logic [15:0] t, new_amp;
    cyc++;
    if (m_playing != 0 && m_amp != 16'h0)
      m_exp = (m_sign > 0) ? m_amp : 16'(32'h10000 - {16'h0, m_amp});
    else
      m_exp = 16'h0000;
    rdy_before = m_ready;
    t = tgt(m_level);
`ifdef TONE_RAMP_EN
    new_amp = m_amp;
    if (cyc % 256 == 0) begin
      if (m_amp < t)      new_amp = (t - m_amp > 16'h0100) ? m_amp + 16'h0100 : t;
      else if (m_amp > t) new_amp = (m_amp - t > 16'h0100) ? m_amp - 16'h0100 : t;
    end
`else
    new_amp = t;
`endif
    if (m_playing != 0 && cyc == m_seg_start + m_len) begin
      if (m_pend != 0) begin
        m_pend = 0; m_ready = 1;
        if (m_pend_div == 0) m_playing = 0;
        else begin m_len = m_pend_div; m_seg_start = cyc; m_sign = -m_sign; end
      end else begin
        m_seg_start = cyc; m_sign = -m_sign;
      end
    end
    if (note_valid && rdy_before != 0) begin
      d = int'(note_div);
      if (m_playing == 0) begin
        if (d != 0) begin m_playing = 1; m_seg_start = cyc; m_len = d; m_sign = 1; end
      end else begin
        m_pend = 1; m_pend_div = d; m_ready = 0;
      end
    end
    if (vol_up && !vol_down && m_level < 7) m_level++;
    else if (vol_down && !vol_up && m_level > 0) m_level--;
    m_amp = new_amp;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("left",  audio_left,  m_exp);
    chk("right", audio_right, m_exp);
    chk("ready", note_ready,  m_ready);
    chk("level", vol_level,   m_level);
    vol_up = 1'b0; vol_down = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic offer_note(input int div);
    int done;
    done = 0;
    note_div = DIV_W'(div); note_valid = 1'b1;
    for (int k = 0; k < 200 && done == 0; k++) begin
      done = m_ready;
      step();
    end
    note_valid = 1'b0;
    chk("offer_accepted", done, 1);
  endtask

  initial begin
    int r, d;
    rst_n = 1'b0; note_div = '0; note_valid = 1'b0; vol_up = 1'b0; vol_down = 1'b0;
    model_reset();
    #11;
    chk("rst_left",  audio_left,  16'h0000);
    chk("rst_right", audio_right, 16'h0000);
    chk("rst_ready", note_ready,  1);
    chk("rst_level", vol_level,   3'd4);
    #1 rst_n = 1'b1;

    // note 4 from IDLE: first +amp two cycles after the handshake
    offer_note(4);
    step();
    chk("first_pos", audio_left, 16'h4000);
    run(9);
    // retune to 2 mid half-period; ready must drop the cycle after
    offer_note(2);
    chk("ready_drop", note_ready, 0);
    run(12);
    // silence request finishes the half-period then goes quiet
    offer_note(0);
    run(12);
    chk("silent_left", audio_left, 16'h0000);
    chk("silent_ready", note_ready, 1);

    // volume saturation and conflicting pulses
    offer_note(3);
    for (int k = 0; k < 8; k++) begin vol_up = 1'b1; step(); end
    chk("vol_sat_hi", vol_level, 3'd7);
    run(8);
    vol_up = 1'b1; vol_down = 1'b1; step();
    chk("vol_both", vol_level, 3'd7);
    for (int k = 0; k < 5; k++) begin vol_down = 1'b1; step(); end
    chk("vol_down5", vol_level, 3'd2);
    run(8);

    // reset while a note is pending
    offer_note(6);
    run(2);
    offer_note(2);
    chk("pend_ready", note_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_left",  audio_left, 16'h0000);
    chk("arst_ready", note_ready, 1);
    chk("arst_level", vol_level,  3'd4);
    #2 rst_n = 1'b1;
    model_reset();
    run(12);
    chk("no_stale_note", audio_left, 16'h0000);

    // fastest tone
    offer_note(1);
    run(6);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0) vol_up = 1'b1;
      if (r == 1) vol_down = 1'b1;
      if (r == 2) begin vol_up = 1'b1; vol_down = 1'b1; end
      d = $urandom_range(0, 9);
      if (d == 9) d = $urandom_range(10, 40);
      note_div   = DIV_W'(d);
      note_valid = ($urandom_range(0, 5) == 0);
      step();
    end
    note_valid = 1'b0;
    run(50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
